uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// UART receiver with Prescale-times oversampling, 3-sample majority voting
// per bit, optional even/odd parity and a single stop bit.
//
// state  | meaning
// IDLE   | line idle; first low cycle is edge 0 of the start bit
// START  | timing the start bit; sampled high means glitch, back to IDLE
// DATA   | shifting in DATA_WIDTH bits, LSB first
// PARITY | sampling parity bit and comparing with computed parity
// STOP   | sampling stop bit; raises Data_Valid or Stp_Err near bit end
module uart_rx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [5:0]            Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_Valid,
  output logic                  Par_Err,
  output logic                  Stp_Err
);

  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                r_state;
  logic [5:0]            r_presc;
  logic [5:0]            r_edge_cnt;
  logic [BW-1:0]         r_bit_cnt;
  logic                  r_par_en;
  logic                  r_par_typ;
  logic                  r_par_bad;
  logic                  r_s0;
  logic                  r_s1;
  logic                  r_bit;
  logic [DATA_WIDTH-1:0] r_shift;

  logic [5:0] w_presc_sel;
  logic [5:0] w_half;
  logic [5:0] w_samp_a;
  logic [5:0] w_samp_b;
  logic [5:0] w_samp_c;
  logic [5:0] w_last;
  logic [5:0] w_pre_last;
  logic       w_maj;
  logic       w_exp_par;
  logic       w_bit_end;
  logic       w_pre_end;
  logic       w_samp_end;

  // Unsupported ratios fall back to 8; sample points sit around mid-bit.
  always_comb begin
    w_presc_sel = ((Prescale == 6'd16) || (Prescale == 6'd32)) ? Prescale : 6'd8;
    w_half      = {1'b0, r_presc[5:1]};
    w_samp_a    = w_half - 6'd1;
    w_samp_b    = w_half;
    w_samp_c    = w_half + 6'd1;
    w_last      = r_presc - 6'd1;
    w_pre_last  = r_presc - 6'd2;
    w_maj       = (r_s0 & r_s1) | (r_s0 & RX_IN) | (r_s1 & RX_IN);
    w_exp_par   = (^r_shift) ^ r_par_typ;
    w_bit_end   = (r_edge_cnt == w_last);
    w_pre_end   = (r_edge_cnt == w_pre_last);
    w_samp_end  = (r_edge_cnt == w_samp_c);
  end

  // Mid-bit samplers; the bit value is resolved on the third sample.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_s0  <= 1'b0;
      r_s1  <= 1'b0;
      r_bit <= 1'b0;
    end else if (r_state != IDLE) begin
      if (r_edge_cnt == w_samp_a) r_s0 <= RX_IN;
      if (r_edge_cnt == w_samp_b) r_s1 <= RX_IN;
      if (w_samp_end) r_bit <= w_maj;
    end
  end

  // Data shift register, filled LSB first from the top.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_shift <= '0;
    end else if ((r_state == DATA) && w_samp_end) begin
      r_shift <= {w_maj, r_shift[DATA_WIDTH-1:1]};
    end
  end

  // Frame sequencer with registered result pulses. Pulses are raised one
  // cycle before the bit ends so they are visible in the bit's last cycle.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state    <= IDLE;
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
      r_presc    <= 6'd8;
      r_par_en   <= 1'b0;
      r_par_typ  <= 1'b0;
      r_par_bad  <= 1'b0;
      P_DATA     <= '0;
      Data_Valid <= 1'b0;
      Par_Err    <= 1'b0;
      Stp_Err    <= 1'b0;
    end else begin
      Data_Valid <= 1'b0;
      Par_Err    <= 1'b0;
      Stp_Err    <= 1'b0;
      if (w_bit_end) begin
        r_edge_cnt <= '0;
      end else begin
        r_edge_cnt <= r_edge_cnt + 6'd1;
      end
      case (r_state)
        IDLE: begin
          r_bit_cnt  <= '0;
          r_edge_cnt <= '0;
          if (!RX_IN) begin
            // The detection cycle itself counts as edge 0.
            r_state    <= START;
            r_edge_cnt <= 6'd1;
            r_presc    <= w_presc_sel;
            r_par_en   <= PAR_EN;
            r_par_typ  <= PAR_TYP;
            r_par_bad  <= 1'b0;
          end
        end
        START: begin
          if (w_bit_end) begin
            r_state <= r_bit ? IDLE : DATA;
          end
        end
        DATA: begin
          if (w_bit_end) begin
            if (r_bit_cnt == LAST_BIT) begin
              r_bit_cnt <= '0;
              r_state   <= r_par_en ? PARITY : STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + BW'(1);
            end
          end
        end
        PARITY: begin
          if (w_pre_end && (r_bit != w_exp_par)) begin
            Par_Err   <= 1'b1;
            r_par_bad <= 1'b1;
          end
          if (w_bit_end) begin
            r_state <= STOP;
          end
        end
        STOP: begin
          if (w_pre_end) begin
            if (!r_bit) begin
              Stp_Err <= 1'b1;
            end else if (!r_par_bad) begin
              Data_Valid <= 1'b1;
              P_DATA     <= r_shift;
            end
          end
          if (w_bit_end) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_edge_cnt <= '0;
        end
      endcase
    end
  end

endmodule
